// File: rtl/fmul_stream_ctrl.sv
// ============================================================================
// Module   : fmul_stream_ctrl
// Purpose  : Valid/ready wrapper around a fixed-latency float multiplier with
//            credit-based issue into a result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmul_stream_ctrl #(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               irst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [31:0]                        in_a,
    input  logic [31:0]                        in_b,
    output logic [31:0]                        mul_a,
    output logic [31:0]                        mul_b,
    output logic                               mul_irst,
    input  logic [31:0]                        mul_result,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_data,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    outstanding
);

    localparam int              OW      = $clog2(FIFO_DEPTH + 1);
    localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [OW-1:0]   DEPTH_C = OW'(FIFO_DEPTH);

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [OW-1:0]      count_q;
    logic [OW-1:0]      count_d;
    logic [OW-1:0]      outst_q;
    logic [OW-1:0]      outst_d;
    logic               pop;
    logic               push;
    logic               issue;
    logic               clr;

    assign clr       = irst | flush;
    assign mul_irst  = clr;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign busy      = (outst_q != '0);
    assign outstanding = outst_q;

    assign pop   = out_valid & out_ready;
    assign push  = vld_q[LATENCY-1];
    // A credit is every slot not yet claimed by an in-flight op or FIFO entry;
    // a pop in this cycle returns its credit immediately.
    assign in_ready = ~clr & ((outst_q - OW'(pop)) < DEPTH_C);
    assign issue    = in_valid & in_ready;

    assign mul_a = issue ? in_a : 32'h0;
    assign mul_b = issue ? in_b : 32'h0;

    generate
        if (LATENCY > 1) begin : g_vld_shift
            assign vld_d = {vld_q[LATENCY-2:0], issue};
        end else begin : g_vld_single
            assign vld_d = issue;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + OW'(1);
            2'b01:   count_d = count_q - OW'(1);
            default: count_d = count_q;
        endcase

        outst_d = outst_q;
        case ({issue, pop})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            outst_q <= outst_d;
            if (push) begin
                mem_q[wr_ptr_q] <= mul_result;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/fmul_stream_ctrl.md
Name: fmul_stream_ctrl

Overview:
- Streaming wrapper that sits directly upstream and downstream of the 3-stage float multiplier.
- Accepts operand pairs over valid/ready and drives them into the multiplier's a/b inputs.
- Tracks in-flight operations with a valid shift register, since the multiplier carries no valid.
- Captures multiplier results into an output FIFO with valid/ready back-pressure. Credit-based issue guarantees no result is ever dropped.

Parameters:
- LATENCY, 3: cycles from operands presented on mul_a/mul_b to a valid mul_result. Must match the multiplier.
- FIFO_DEPTH, 4: result FIFO entries. Power of 2, minimum LATENCY+1.

Ports:
- clk  input  1  clock
- irst  input  1  synchronous active-high reset
- flush  input  1  synchronous pipeline/FIFO clear
- in_valid  input  1  operand pair valid
- in_ready  output  1  operand pair accepted when in_valid & in_ready
- in_a  input  32  IEEE-754 single operand A
- in_b  input  32  IEEE-754 single operand B
- mul_a  output  32  to multiplier a
- mul_b  output  32  to multiplier b
- mul_irst  output  1  to multiplier irst
- mul_result  input  32  from multiplier result
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_data  output  32  FIFO head product
- busy  output  1  any op in flight or in FIFO
- outstanding  output  $clog2(FIFO_DEPTH+1)  in-flight + FIFO occupancy

Behaviour:
- Reset (irst=1 at a clock edge):
  - vld shift register cleared; FIFO pointers and count = 0; outstanding = 0.
  - out_valid = 0, busy = 0; out_data is don't-care but zeroed.
  - mul_irst = irst | flush, combinational, so the multiplier clears in the same cycle.
- Issue:
  - pop = out_valid & out_ready.
  - in_ready = !flush & !irst & ((outstanding - pop) < FIFO_DEPTH). A same-cycle pop frees a credit.
  - issue = in_valid & in_ready.
  - mul_a/mul_b = in_a/in_b when issue, else 32'h0. Combinational, because the multiplier samples at the next edge.
- Tracking:
  - vld[0] <= issue; vld[i] <= vld[i-1] for i = 1..LATENCY-1.
  - In the cycle where vld[LATENCY-1] = 1, mul_result is valid and is pushed to the FIFO at that edge.
- Latency: issue in cycle t puts the result on out_data with out_valid = 1 from cycle t+LATENCY+1 (t+4 by default).
- FIFO:
  - Registered storage, wr/rd pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
  - out_valid = (count != 0); out_data = mem[rd_ptr].
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when full is impossible by the credit rule; the bench asserts it never happens.
- Outstanding counter:
  - +1 on issue, -1 on pop, unchanged on both or neither.
  - Saturates at FIFO_DEPTH by construction.
  - busy = (outstanding != 0).
- Throughput: with out_ready held high, one product per cycle sustained, and in_ready stays 1.
- Ordering: strictly in-order; the FIFO preserves issue order.
- Flush (flush=1 at an edge):
  - Same effect as irst on vld, FIFO and outstanding.
  - in_ready = 0 during the flush cycle; an in-flight product is discarded.
  - Normal operation resumes the next cycle.
- irst or flush mid-stream: all pending results are lost. No partial result is emitted, because mul_irst zeroes the multiplier stages in the same edge.
- Output back-pressure: with out_ready held low, outstanding reaches FIFO_DEPTH, in_ready drops, and the FIFO holds its contents stable.

Test Plan:
1. Single op: in_a=0x40000000 (2.0), in_b=0x40400000 (3.0), issue at t -> out_valid rises at t+4 with out_data=0x40C00000 (6.0); outstanding 1 at t+1..t+4, 0 at t+5 after pop.
2. Back-to-back stream: 16 pairs {k.0 × 2.0}, out_ready=1 -> in_ready never drops, 16 consecutive results in order, one per cycle from t+4.
3. Back-pressure: out_ready=0, in_valid=1 continuously -> exactly 4 issues accepted, then in_ready=0. Raising out_ready pops 4 correct results and allows the next issue in the same cycle as the first pop.
4. Special values: 0x7F800000×0x3F800000 -> 0x7F800000; 0x00000000×0xC0000000 -> 0x80000000; 0x7F000000×0x7F000000 -> 0x7F800000 (overflow). Each arrives at t+4.
5. Flush mid-flight: issue 3 ops, assert flush while 2 are in flight and 1 is in the FIFO -> mul_irst=1 that cycle; next cycle out_valid=0, outstanding=0. A new op issued after that returns the correct product at +4.
6. Reset mid-operation: irst asserted with FIFO full -> the following cycle shows out_valid=0, busy=0, in_ready=1, and no stale result ever appears.
